fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake and
// presents one instruction per consume to IF/ID, with MIPS delay-slot redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrF,
    output logic [31:0] pc_plus4F,
    output logic        fetch_valid,
    output logic        fetch_fault
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   buf_instr;
    logic              pend_valid;
    logic [XLEN-1:0]   pend_target;

    logic              redir;
    logic [XLEN-1:0]   redir_target;
    logic [XLEN-1:0]   redir_aligned;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   next_pc;
    logic              consume;
    logic              capture;

    // Redirect selection; jump wins over a taken branch.
    always_comb begin
        redir         = jump | branch_taken;
        redir_target  = jump ? jump_target : branch_target;
        redir_aligned = {redir_target[XLEN-1:2], 2'b00};
    end

    // Sequencing: an instruction is consumed either straight off an ack or out of the hold buffer.
    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        consume  = ((state == FETCH) & imem_ack & ~stall) | ((state == HOLD) & ~stall);
        capture  = (state == FETCH) & imem_ack & stall;
        if (redir) begin
            next_pc = redir_aligned;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end else begin
            next_pc = pc_plus4;
        end
    end

    // Presentation to IF/ID: rdata passes straight through in FETCH, buffer drives it in HOLD.
    always_comb begin
        imem_req    = (state == FETCH);
        imem_addr   = pc;
        fetch_valid = (state == HOLD) | imem_ack;
        if (state == HOLD) begin
            instrF = buf_instr;
        end else if (imem_ack) begin
            instrF = imem_rdata;
        end else begin
            instrF = '0;
        end
        pc_plus4F = fetch_valid ? pc_plus4 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= FETCH;
            buf_instr   <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            fetch_fault <= 1'b0;
        end else begin
            if (redir && (redir_target[1:0] != 2'b00)) begin
                fetch_fault <= 1'b1;
            end
            if (consume) begin
                pc         <= next_pc;
                state      <= FETCH;
                pend_valid <= 1'b0;
            end else begin
                if (capture) begin
                    buf_instr <= imem_rdata;
                    state     <= HOLD;
                end
                // A redirect seen with nothing consumed waits for the delay slot to complete.
                if (redir) begin
                    pend_valid  <= 1'b1;
                    pend_target <= redir_aligned;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expected values.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instrF;
    logic [31:0] pc_plus4F;
    logic        fetch_valid;
    logic        fetch_fault;

    int unsigned n_tests;
    int unsigned n_fail;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instrF       (instrF),
        .pc_plus4F    (pc_plus4F),
        .fetch_valid  (fetch_valid),
        .fetch_fault  (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        settle();
        check("rst_req",   32'(imem_req),    32'd1);
        check("rst_addr",  imem_addr,        32'h3000);
        check("rst_instr", instrF,           32'h0);
        check("rst_pc4",   pc_plus4F,        32'h0);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);

        // Zero-wait memory: one instruction per cycle
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = 32'hA000_0000 + 32'(i);
            settle();
            check("zw_addr",  imem_addr,        32'h3000 + 32'(4 * i));
            check("zw_pc4",   pc_plus4F,        32'h3004 + 32'(4 * i));
            check("zw_valid", 32'(fetch_valid), 32'd1);
            check("zw_instr", instrF,           32'hA000_0000 + 32'(i));
            step();
        end

        // Delayed ack: bubbles while waiting, address held
        reset = 1'b1; imem_ack = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("dly_addr",  imem_addr,        32'h3000);
            check("dly_instr", instrF,           32'h0);
            check("dly_valid", 32'(fetch_valid), 32'd0);
            check("dly_pc4",   pc_plus4F,        32'h0);
            step();
        end
        imem_ack = 1'b1; imem_rdata = 32'h1111_0001;
        settle();
        check("dly_ack_instr", instrF,    32'h1111_0001);
        check("dly_ack_pc4",   pc_plus4F, 32'h3004);
        check("dly_ack_addr",  imem_addr, 32'h3000);
        step();

        // Stall on ack at 3004: capture into HOLD
        stall = 1'b1; imem_rdata = 32'h2408_0005;
        settle();
        check("st_addr", imem_addr, 32'h3004);
        step();
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        settle();
        check("hold_req",   32'(imem_req),    32'd0);
        check("hold_instr", instrF,           32'h2408_0005);
        check("hold_pc4",   pc_plus4F,        32'h3008);
        check("hold_valid", 32'(fetch_valid), 32'd1);
        step();
        imem_ack = 1'b1;
        settle();
        check("hold_ign_ack", instrF, 32'h2408_0005);
        step();
        stall = 1'b0; imem_ack = 1'b0;
        settle();
        check("hold_rel_instr", instrF, 32'h2408_0005);
        step();
        settle();
        check("post_hold_addr", imem_addr,     32'h3008);
        check("post_hold_req",  32'(imem_req), 32'd1);

        // Taken branch while delay slot at 3008 is acked
        imem_ack = 1'b1; imem_rdata = 32'h0000_0123;
        branch_taken = 1'b1; branch_target = 32'h3040;
        settle();
        check("br_ds_instr", instrF,    32'h0000_0123);
        check("br_ds_pc4",   pc_plus4F, 32'h300C);
        step();
        branch_taken = 1'b0; imem_ack = 1'b0;
        settle();
        check("br_tgt_addr", imem_addr, 32'h3040);

        // Jump while waiting for ack: pending, delay slot at 3040 completes first
        jump = 1'b1; jump_target = 32'h3100;
        settle();
        check("jp_wait_valid", 32'(fetch_valid), 32'd0);
        step();
        jump = 1'b0;
        settle();
        check("jp_pend_addr", imem_addr, 32'h3040);
        step();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0456;
        settle();
        check("jp_ds_addr",  imem_addr, 32'h3040);
        check("jp_ds_pc4",   pc_plus4F, 32'h3044);
        check("jp_ds_instr", instrF,    32'h0000_0456);
        step();
        imem_ack = 1'b0;
        settle();
        check("jp_tgt_addr", imem_addr, 32'h3100);

        // Misaligned jump target: sticky fault, target aligned down
        jump = 1'b1; jump_target = 32'h3102;
        step();
        jump = 1'b0;
        settle();
        check("mis_fault", 32'(fetch_fault), 32'd1);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        settle();
        check("mis_addr",        imem_addr,        32'h3100);
        check("mis_fault_stick", 32'(fetch_fault), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check("rst2_fault", 32'(fetch_fault), 32'd0);
        check("rst2_addr",  imem_addr,        32'h3000);
        check("rst2_req",   32'(imem_req),    32'd1);

        // Jump beats branch; pc+4 wraps at the top of the address space
        imem_ack = 1'b1;
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        branch_taken = 1'b1; branch_target = 32'h3200;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        settle();
        check("prio_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc4",  pc_plus4F, 32'h0);
        step();
        settle();
        check("wrap_addr", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
